// File: rtl/conf_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
package conf_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PH1,
    GAP1,
    PH2,
    GAP2,
    WAIT,
    DONE
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  // One MSB-first CRC-16 step for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/conf_phase_gen.sv
// Two-phase strobe timer: after a start pulse it walks PH1/GAP1/PH2/GAP2 using
// one down-counter and flags the last GAP2 cycle with bit_done.
module conf_phase_gen
  import conf_loader_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  output state_t phase_next,
  output logic   phi1,
  output logic   phi2,
  output logic   bit_done,
  output logic   last_gap_next
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  state_t           ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phi1_q, phi2_q;

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    case (ph_q)
      PH1: begin
        if (cnt_q == '0) begin
          ph_d  = GAP1;
          cnt_d = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP1: begin
        if (cnt_q == '0) begin
          ph_d  = PH2;
          cnt_d = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PH2: begin
        if (cnt_q == '0) begin
          ph_d  = GAP2;
          cnt_d = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP2: begin
        if (cnt_q == '0) begin
          ph_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (start) begin
          ph_d  = PH1;
          cnt_d = PULSE_LD;
        end
      end
    endcase
    phase_next    = ph_d;
    bit_done      = (ph_q == GAP2) && (cnt_q == '0);
    last_gap_next = (ph_d == GAP2) && (cnt_d == '0);
  end

  // Strobes are registered from the next phase so they rise and fall on clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= IDLE;
      cnt_q  <= '0;
      phi1_q <= 1'b0;
      phi2_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      phi1_q <= (ph_d == PH1);
      phi2_q <= (ph_d == PH2);
    end
  end

  assign phi1 = phi1_q;
  assign phi2 = phi2_q;

endmodule

// File: rtl/config_chain_loader.sv
// Word-to-bit-serial loader for a two-phase tile configuration latch chain.
// Optional CRC-16 of the shifted bits is enabled with CONF_LOADER_CRC_EN.
module config_chain_loader
  import conf_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int CHAIN_BITS = 256,
  parameter int PULSE_W    = 2,
  parameter int GAP_W      = 1
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic              CONF_DATA,
  output logic              CONF_PHI1,
  output logic              CONF_PHI2,
  output logic              busy,
  output logic              done,
  output logic              err_len
`ifdef CONF_LOADER_CRC_EN
  ,
  output logic [15:0]       crc_out
`endif
);

  localparam int BIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int BC_W   = $clog2(CHAIN_BITS + WORD_W + 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_W - 1);
  localparam logic [BC_W-1:0]   BC_MAX    = BC_W'(CHAIN_BITS + WORD_W);
  localparam logic [BC_W-1:0]   BC_TARGET = BC_W'(CHAIN_BITS);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
  logic                last_q, last_d;
  logic                conf_data_q, conf_data_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_len_q, err_len_d;
`ifdef CONF_LOADER_CRC_EN
  logic [15:0]         crc_q, crc_d;
`endif

  logic                accept, load_word, word_end;
  logic [WORD_W-1:0]   sh_next;
  state_t              phase_next;
  logic                bit_done, last_gap_next;

  conf_phase_gen #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W)
  ) u_phase (
    .clk           (CLK),
    .rst_n         (resetn),
    .start         (state_q == SETUP),
    .phase_next    (phase_next),
    .phi1          (CONF_PHI1),
    .phi2          (CONF_PHI2),
    .bit_done      (bit_done),
    .last_gap_next (last_gap_next)
  );

  // Handshake: a word transfers on a rising edge where s_valid and s_ready are
  // both high; s_ready is registered and s_valid without s_ready does nothing.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bidx_d      = bidx_q;
    bitcnt_d    = bitcnt_q;
    last_d      = last_q;
    conf_data_d = conf_data_q;
    busy_d      = busy_q;
    err_len_d   = err_len_q;
`ifdef CONF_LOADER_CRC_EN
    crc_d       = crc_q;
`endif
    accept      = s_valid && s_ready_q;
    load_word   = 1'b0;
    word_end    = (bidx_q == BIDX_LAST);
    sh_next     = shreg_q << 1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load_word = 1'b1;
          bitcnt_d  = '0;
          err_len_d = 1'b0;
          busy_d    = 1'b1;
`ifdef CONF_LOADER_CRC_EN
          crc_d     = CRC_INIT;
`endif
        end
      end
      SETUP: begin
        state_d = phase_next;
        if (bitcnt_q != BC_MAX) bitcnt_d = bitcnt_q + BC_W'(1);
`ifdef CONF_LOADER_CRC_EN
        crc_d = crc16_step(crc_q, conf_data_q);
`endif
      end
      PH1, GAP1, PH2, GAP2: begin
        if (bit_done) begin
          if (!word_end) begin
            state_d     = SETUP;
            shreg_d     = sh_next;
            bidx_d      = bidx_q + BIDX_W'(1);
            conf_data_d = sh_next[WORD_W-1];
          end else if (last_q) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            err_len_d = (bitcnt_q != BC_TARGET);
          end else if (accept) begin
            load_word = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = phase_next;
        end
      end
      WAIT: begin
        if (accept) load_word = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_word) begin
      state_d     = SETUP;
      shreg_d     = s_data;
      bidx_d      = '0;
      last_d      = s_last;
      conf_data_d = s_data[WORD_W-1];
    end

    done_d    = (state_d == DONE);
    // Ready in the final GAP2 cycle of a non-last word keeps a streaming load bubble-free.
    s_ready_d = (state_d == IDLE) || (state_d == WAIT) ||
                (last_gap_next && word_end && !last_q);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bidx_q      <= '0;
      bitcnt_q    <= '0;
      last_q      <= 1'b0;
      conf_data_q <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
`ifdef CONF_LOADER_CRC_EN
      crc_q       <= CRC_INIT;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bidx_q      <= bidx_d;
      bitcnt_q    <= bitcnt_d;
      last_q      <= last_d;
      conf_data_q <= conf_data_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
`ifdef CONF_LOADER_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign CONF_DATA = conf_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_len   = err_len_q;
`ifdef CONF_LOADER_CRC_EN
  assign crc_out   = crc_q;
`endif

endmodule
